// File: rtl/nand_stim_checker.sv
// nand_stim_checker
//   Self-checking stimulus sequencer for a NAND stage. On an accepted start it
//   holds a=b=0 for LEAD cycles, then applies (a,b) = 00, 10, 01, 11 for DWELL
//   cycles each. It samples w SETTLE cycles into each dwell and counts the
//   mismatches against ~(a&b). The count saturates at 4. It reports done, pass
//   and err_count at the end of the run.
//
// Ports
//   clk        in   clock; every state update happens on its rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   run request; only looked at in IDLE
//   w          in   output of the NAND stage under check
//   a, b       out  NAND stimulus inputs (registered)
//   busy       out  high from run acceptance until completion
//   done       out  one-cycle pulse at run completion
//   pass       out  last completed run had no mismatches
//   err_count  out  saturating mismatch count (0..4)
//   vec_idx    out  index of the vector being driven (0..3)
module nand_stim_checker #(
    parameter int unsigned LEAD   = 25,
    parameter int unsigned DWELL  = 30,
    parameter int unsigned SETTLE = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       w,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] vec_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_APPLY,
        S_DONE
    } state_t;

    localparam int unsigned CNT_MAX = (LEAD > DWELL) ? LEAD : DWELL;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    // Terminal counter values. LEAD_LAST is never reached when LEAD = 0,
    // because acceptance then goes directly to APPLY.
    localparam logic [CW-1:0] LEAD_LAST  = CW'((LEAD == 0) ? 0 : LEAD - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] SMP_AT     = CW'(SETTLE - 1);

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt,   w_cnt_nxt;
    logic [1:0]      r_vec,   w_vec_nxt;
    logic            r_a,     w_a_nxt;
    logic            r_b,     w_b_nxt;
    logic            r_busy,  w_busy_nxt;
    logic            r_done,  w_done_nxt;
    logic            r_pass,  w_pass_nxt;
    logic [2:0]      r_err,   w_err_nxt;
    logic [1:0]      w_vec_inc;
    logic            w_exp;

    assign w_vec_inc = r_vec + 2'd1;
    // The expected NAND value comes from the registered stimulus that is on a/b now.
    assign w_exp     = ~(r_a & r_b);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_vec_nxt   = r_vec;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_pass_nxt  = r_pass;
        w_err_nxt   = r_err;

        case (r_state)
            S_IDLE: begin
                w_a_nxt = 1'b0;
                w_b_nxt = 1'b0;
                if (start) begin
                    w_busy_nxt  = 1'b1;
                    w_err_nxt   = '0;
                    w_pass_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_vec_nxt   = '0;
                    w_state_nxt = (LEAD == 0) ? S_APPLY : S_LEAD;
                end
            end

            S_LEAD: begin
                if (r_cnt == LEAD_LAST) begin
                    w_state_nxt = S_APPLY;
                    w_cnt_nxt   = '0;
                    w_vec_nxt   = '0;
                    w_a_nxt     = 1'b0;
                    w_b_nxt     = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            S_APPLY: begin
                if ((r_cnt == SMP_AT) && (w != w_exp) && (r_err != 3'd4))
                    w_err_nxt = r_err + 3'd1;

                if (r_cnt == DWELL_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_vec == 2'd3) begin
                        // DWELL > SETTLE, so r_err is already final at this edge.
                        w_state_nxt = S_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (r_err == 3'd0);
                        w_vec_nxt   = '0;
                        w_a_nxt     = 1'b0;
                        w_b_nxt     = 1'b0;
                    end else begin
                        // Vector encoding: a = idx[0], b = idx[1].
                        w_vec_nxt = w_vec_inc;
                        w_a_nxt   = w_vec_inc[0];
                        w_b_nxt   = w_vec_inc[1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_vec   <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_vec   <= w_vec_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign a         = r_a;
    assign b         = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign vec_idx   = r_vec;

endmodule
